// File: rtl/inst_mem_arbiter_pkg.sv
// Shared types and defaults for the instruction-memory arbiter slice.
// Port identifiers, the in-flight tag record and a flush-kill helper.
package inst_mem_pkg;

    localparam int unsigned DEFAULT_ADDR_WIDTH  = 12;
    localparam int unsigned DEFAULT_DATA_WIDTH  = 32;
    localparam int unsigned DEFAULT_RAM_LATENCY = 2;

    localparam int unsigned LATENCY_LOW  = 1;
    localparam int unsigned LATENCY_HIGH = 2;

    typedef enum logic {
        PORT_F = 1'b0,
        PORT_L = 1'b1
    } port_id_t;

    typedef struct packed {
        logic     valid;
        port_id_t port;
    } tag_t;

    // A flush drops fetch-owned tags only; loader tags pass through untouched.
    function automatic tag_t kill_fetch_tag(tag_t t, logic kill);
        tag_t r;
        r = t;
        if (kill && (t.port == PORT_F)) begin
            r.valid = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/inst_mem_arbiter_if.sv
// Request/response and BRAM-port bundle for inst_mem_arbiter.
// slave = arbiter view, master = requesters plus BRAM view.
interface inst_mem_arbiter_if
    import inst_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

    logic                  f_req_valid;
    logic [ADDR_WIDTH-1:0] f_req_addr;
    logic                  f_req_ready;
    logic                  f_flush;
    logic                  f_rsp_valid;
    logic [DATA_WIDTH-1:0] f_rsp_data;

    logic                  l_req_valid;
    logic                  l_req_we;
    logic [ADDR_WIDTH-1:0] l_req_addr;
    logic [DATA_WIDTH-1:0] l_req_wdata;
    logic                  l_req_ready;
    logic                  l_rsp_valid;
    logic [DATA_WIDTH-1:0] l_rsp_data;

    logic                  ram_en;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_din;
    logic                  ram_regce;
    logic                  ram_rst;
    logic [DATA_WIDTH-1:0] ram_dout;

    modport slave (
        input  f_req_valid, f_req_addr, f_flush,
        output f_req_ready, f_rsp_valid, f_rsp_data,
        input  l_req_valid, l_req_we, l_req_addr, l_req_wdata,
        output l_req_ready, l_rsp_valid, l_rsp_data,
        output ram_en, ram_we, ram_addr, ram_din, ram_regce, ram_rst,
        input  ram_dout
    );

    modport master (
        output f_req_valid, f_req_addr, f_flush,
        input  f_req_ready, f_rsp_valid, f_rsp_data,
        output l_req_valid, l_req_we, l_req_addr, l_req_wdata,
        input  l_req_ready, l_rsp_valid, l_rsp_data,
        input  ram_en, ram_we, ram_addr, ram_din, ram_regce, ram_rst,
        output ram_dout
    );

endinterface

// File: rtl/inst_mem_arbiter_tag_pipe.sv
// DEPTH-stage shift register of {valid, port} tags tracking BRAM accesses
// in flight; kill_f clears every fetch-owned stage as it advances.
module inst_mem_tag_pipe
    import inst_mem_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_RAM_LATENCY
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t push_tag,
    input  logic kill_f,
    output logic head_valid,
    output tag_t tail_tag
);

    tag_t stage_q [DEPTH];
    tag_t stage_d [DEPTH];

    always_comb begin
        stage_d[0] = kill_fetch_tag(push_tag, kill_f);
        for (int unsigned i = 1; i < DEPTH; i++) begin
            stage_d[i] = kill_fetch_tag(stage_q[i-1], kill_f);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign head_valid = stage_q[0].valid;
    assign tail_tag   = stage_q[DEPTH-1];

endmodule

// File: rtl/inst_mem_arbiter.sv
// Round-robin arbiter sharing one instruction BRAM port between fetch and
// loader; responses return RAM_LATENCY cycles after issue, fetch ones flushable.
module inst_mem_arbiter
    import inst_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int unsigned RAM_LATENCY = DEFAULT_RAM_LATENCY
) (
    input  logic               clka,
    input  logic               rsta_n,
    inst_mem_arbiter_if.slave  bus
);

    logic     want_f;
    logic     want_l;
    logic     grant_f;
    logic     grant_l;
    port_id_t last_grant_q;
    port_id_t last_grant_d;
    tag_t     push_tag;
    tag_t     tail_tag;
    logic     head_valid;

    // Nothing is accepted while reset is held, so no pre-reset tag can leak out.
    always_comb begin
        want_f  = bus.f_req_valid & ~bus.f_flush & rsta_n;
        want_l  = bus.l_req_valid & rsta_n;
        grant_f = want_f & (~want_l | (last_grant_q == PORT_L));
        grant_l = want_l & ~grant_f;

        last_grant_d = last_grant_q;
        if (grant_f) begin
            last_grant_d = PORT_F;
        end else if (grant_l) begin
            last_grant_d = PORT_L;
        end
    end

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            last_grant_q <= PORT_L;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        bus.f_req_ready = grant_f;
        bus.l_req_ready = grant_l;

        bus.ram_en   = grant_f | grant_l;
        bus.ram_we   = grant_l & bus.l_req_we;
        bus.ram_addr = grant_l ? bus.l_req_addr : bus.f_req_addr;
        bus.ram_din  = grant_l ? bus.l_req_wdata : '0;
        bus.ram_rst  = 1'b0;

        push_tag.valid = grant_f | grant_l;
        push_tag.port  = grant_l ? PORT_L : PORT_F;
    end

    inst_mem_tag_pipe #(
        .DEPTH (RAM_LATENCY)
    ) u_tag_pipe (
        .clk        (clka),
        .rst_n      (rsta_n),
        .push_tag   (push_tag),
        .kill_f     (bus.f_flush),
        .head_valid (head_valid),
        .tail_tag   (tail_tag)
    );

    // Output register only needs clocking when a read sits in the first stage.
    always_comb begin
        bus.ram_regce   = (RAM_LATENCY == LATENCY_HIGH) ? head_valid : 1'b1;
        bus.f_rsp_valid = tail_tag.valid & (tail_tag.port == PORT_F) & ~bus.f_flush;
        bus.l_rsp_valid = tail_tag.valid & (tail_tag.port == PORT_L);
        bus.f_rsp_data  = bus.ram_dout;
        bus.l_rsp_data  = bus.ram_dout;
    end

endmodule
